if_fetch: RTL and testbench

IF_FETCH -- requirements
Module: if_fetch

---
 rtl/if_fetch_pkg.sv | 24 ++
 rtl/if_fetch_if.sv | 31 +++
 rtl/if_fetch_npc.sv | 40 ++++
 rtl/if_fetch.sv | 47 ++++
 tb/tb_if_fetch.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/if_fetch_pkg.sv
// Shared constants and types for the instruction-fetch stage: reset/handler
// vectors, exception codes, fetch-range bounds and next-PC select encodings.
package if_fetch_pkg;

    localparam logic [31:0] PC_RESET    = 32'h0000_3000;
    localparam logic [31:0] EXC_HANDLER = 32'h0000_4180;
    localparam logic [31:0] INSTR_NOP   = 32'h0000_0000;
    localparam logic [4:0]  CODE_NONE   = 5'd0;
    localparam logic [4:0]  CODE_ADEL   = 5'd4;
    localparam logic [31:0] FETCH_LO    = 32'h0000_3000;
    localparam logic [31:0] FETCH_HI    = 32'h0000_6FFC;

    typedef enum logic [1:0] {
        NPC_SEQ    = 2'd0,
        NPC_BRANCH = 2'd1,
        NPC_JUMP   = 2'd2,
        NPC_JREG   = 2'd3
    } npc_sel_e;

    function automatic logic in_fetch_range(input logic [31:0] pc);
        return (pc >= FETCH_LO) && (pc <= FETCH_HI);
    endfunction

endpackage

// File: rtl/if_fetch_if.sv
// Bundle of the fetch stage's control inputs, instruction-memory port and
// F-stage outputs towards IF_ID; master is the fetch stage itself.
interface if_fetch_if;

    logic        Req;
    logic        Stall;
    logic        d_isEret;
    logic [31:0] EPC;
    logic [1:0]  d_npc_sel;
    logic [31:0] d_npc_target;
    logic        d_isBranchJump;
    logic [31:0] i_inst_addr;
    logic [31:0] i_inst_rdata;
    logic [31:0] f_PC;
    logic [31:0] f_Instr;
    logic        f_BD;
    logic [4:0]  f_ExcCode;

    modport master (
        input  Req, Stall, d_isEret, EPC, d_npc_sel, d_npc_target,
               d_isBranchJump, i_inst_rdata,
        output i_inst_addr, f_PC, f_Instr, f_BD, f_ExcCode
    );

    modport slave (
        output Req, Stall, d_isEret, EPC, d_npc_sel, d_npc_target,
               d_isBranchJump, i_inst_rdata,
        input  i_inst_addr, f_PC, f_Instr, f_BD, f_ExcCode
    );

endinterface

// File: rtl/if_fetch_npc.sv
// if_npc: purely combinational next-PC selection.
// Priority: exception request > eret (unstalled) > stall hold > npc_sel.
module if_npc
    import if_fetch_pkg::*;
(
    input  logic [31:0] i_pc,
    input  logic        i_req,
    input  logic        i_stall,
    input  logic        i_is_eret,
    input  logic [31:0] i_epc,
    input  logic [1:0]  i_npc_sel,
    input  logic [31:0] i_npc_target,
    output logic [31:0] o_npc
);

    logic [31:0] w_pc_plus4;

    assign w_pc_plus4 = i_pc + 32'd4;

    always_comb begin
        o_npc = w_pc_plus4;
        if (i_req) begin
            o_npc = EXC_HANDLER;
        end else if (i_is_eret && !i_stall) begin
            o_npc = i_epc;
        end else if (i_stall) begin
            o_npc = i_pc;
        end else begin
            // Targets are taken as-is; a misaligned jr target faults in F later.
            unique case (npc_sel_e'(i_npc_sel))
                NPC_SEQ:    o_npc = w_pc_plus4;
                NPC_BRANCH: o_npc = i_npc_target;
                NPC_JUMP:   o_npc = i_npc_target;
                NPC_JREG:   o_npc = i_npc_target;
                default:    o_npc = w_pc_plus4;
            endcase
        end
    end

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage: PC register, fetch-address fault detection and F outputs.
// Optional FETCH_RANGE_CHK_EN also faults PCs outside the fetch window.
module if_fetch
    import if_fetch_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    if_fetch_if.master   bus
);

    logic [31:0] r_pc;
    logic [31:0] w_npc;
    logic        w_fault;

    if_npc u_npc (
        .i_pc         (r_pc),
        .i_req        (bus.Req),
        .i_stall      (bus.Stall),
        .i_is_eret    (bus.d_isEret),
        .i_epc        (bus.EPC),
        .i_npc_sel    (bus.d_npc_sel),
        .i_npc_target (bus.d_npc_target),
        .o_npc        (w_npc)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc <= PC_RESET;
        end else begin
            r_pc <= w_npc;
        end
    end

`ifdef FETCH_RANGE_CHK_EN
    assign w_fault = (r_pc[1:0] != 2'b00) || !in_fetch_range(r_pc);
`else
    assign w_fault = (r_pc[1:0] != 2'b00);
`endif

    assign bus.i_inst_addr = r_pc;
    assign bus.f_PC        = r_pc;
    assign bus.f_Instr     = w_fault ? INSTR_NOP : bus.i_inst_rdata;
    assign bus.f_ExcCode   = w_fault ? CODE_ADEL : CODE_NONE;
    // An eret in D is never itself a branch, so its successor is no delay slot.
    assign bus.f_BD        = bus.d_isBranchJump && !bus.d_isEret;

endmodule

// File: tb/tb_if_fetch.sv
// Self-checking bench for if_fetch: vector table walked cycle by cycle with a
// next-PC scoreboard, then hand-written reset-override sequences.
module tb_if_fetch;

    logic clk;
    logic reset;

    if_fetch_if bus ();

    if_fetch dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef FETCH_RANGE_CHK_EN
    localparam logic [4:0] RC = 5'd4;
`else
    localparam logic [4:0] RC = 5'd0;
`endif

    function automatic logic [31:0] mem(input logic [31:0] a);
        return a ^ 32'hDEAD_0000;
    endfunction

    always_comb bus.i_inst_rdata = mem(bus.i_inst_addr);

    typedef struct {
        logic        req;
        logic        stall;
        logic        eret;
        logic [31:0] epc;
        logic [1:0]  sel;
        logic [31:0] target;
        logic        bj;
        logic [31:0] exp_pc;
        logic        exp_bd;
        logic [4:0]  exp_exc;
        logic [31:0] exp_next;
    } vec_t;

    vec_t        vecs[19];
    logic [31:0] sb_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h, expected %08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic req, input logic stall, input logic eret,
                         input logic [31:0] epc, input logic [1:0] sel,
                         input logic [31:0] target, input logic bj);
        bus.Req            = req;
        bus.Stall          = stall;
        bus.d_isEret       = eret;
        bus.EPC            = epc;
        bus.d_npc_sel      = sel;
        bus.d_npc_target   = target;
        bus.d_isBranchJump = bj;
    endtask

    task automatic pop_check(input string name);
        logic [31:0] e;
        if (sb_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: scoreboard empty, got %08h", name, bus.f_PC);
        end else begin
            e = sb_q.pop_front();
            check(name, bus.f_PC, e);
        end
    endtask

    function automatic vec_t mk(input logic req, input logic stall, input logic eret,
                                input logic [31:0] epc, input logic [1:0] sel,
                                input logic [31:0] target, input logic bj,
                                input logic [31:0] exp_pc, input logic exp_bd,
                                input logic [4:0] exp_exc, input logic [31:0] exp_next);
        vec_t v;
        v.req = req; v.stall = stall; v.eret = eret; v.epc = epc; v.sel = sel;
        v.target = target; v.bj = bj; v.exp_pc = exp_pc; v.exp_bd = exp_bd;
        v.exp_exc = exp_exc; v.exp_next = exp_next;
        return v;
    endfunction

    initial begin
        //              req stl ert epc           sel   target        bj  pc            bd  exc    next
        vecs[0]  = mk(0, 0, 0, 32'h0,        2'd0, 32'h0,        0, 32'h0000_3000, 0, 5'd0, 32'h0000_3004);
        vecs[1]  = mk(0, 0, 0, 32'h0,        2'd0, 32'h0,        0, 32'h0000_3004, 0, 5'd0, 32'h0000_3008);
        vecs[2]  = mk(0, 0, 0, 32'h0,        2'd0, 32'h0,        0, 32'h0000_3008, 0, 5'd0, 32'h0000_300C);
        vecs[3]  = mk(0, 0, 0, 32'h0,        2'd0, 32'h0,        0, 32'h0000_300C, 0, 5'd0, 32'h0000_3010);
        vecs[4]  = mk(0, 0, 0, 32'h0,        2'd1, 32'h0000_3040, 1, 32'h0000_3010, 1, 5'd0, 32'h0000_3040);
        vecs[5]  = mk(0, 0, 0, 32'h0,        2'd2, 32'h0000_3020, 1, 32'h0000_3040, 1, 5'd0, 32'h0000_3020);
        vecs[6]  = mk(0, 1, 0, 32'h0,        2'd0, 32'h0,        0, 32'h0000_3020, 0, 5'd0, 32'h0000_3020);
        vecs[7]  = mk(0, 1, 0, 32'h0,        2'd1, 32'h0000_3500, 1, 32'h0000_3020, 1, 5'd0, 32'h0000_3020);
        vecs[8]  = mk(1, 1, 0, 32'h0,        2'd0, 32'h0,        0, 32'h0000_3020, 0, 5'd0, 32'h0000_4180);
        vecs[9]  = mk(0, 0, 1, 32'h0000_3100, 2'd0, 32'h0,        1, 32'h0000_4180, 0, 5'd0, 32'h0000_3100);
        vecs[10] = mk(0, 1, 1, 32'h0000_3200, 2'd0, 32'h0,        0, 32'h0000_3100, 0, 5'd0, 32'h0000_3100);
        vecs[11] = mk(0, 0, 0, 32'h0,        2'd3, 32'h0000_3002, 1, 32'h0000_3100, 1, 5'd0, 32'h0000_3002);
        vecs[12] = mk(0, 0, 0, 32'h0,        2'd0, 32'h0,        0, 32'h0000_3002, 0, 5'd4, 32'h0000_3006);
        vecs[13] = mk(0, 0, 0, 32'h0,        2'd3, 32'h0000_7000, 1, 32'h0000_3006, 1, 5'd4, 32'h0000_7000);
        vecs[14] = mk(0, 0, 0, 32'h0,        2'd0, 32'h0,        0, 32'h0000_7000, 0, RC,   32'h0000_7004);
        vecs[15] = mk(1, 0, 1, 32'h0000_3300, 2'd1, 32'h0000_3400, 0, 32'h0000_7004, 0, RC,   32'h0000_4180);
        vecs[16] = mk(0, 0, 0, 32'h0,        2'd3, 32'hFFFF_FFFC, 1, 32'h0000_4180, 1, 5'd0, 32'hFFFF_FFFC);
        vecs[17] = mk(0, 0, 0, 32'h0,        2'd0, 32'h0,        0, 32'hFFFF_FFFC, 0, RC,   32'h0000_0000);
        vecs[18] = mk(0, 0, 0, 32'h0,        2'd0, 32'h0,        0, 32'h0000_0000, 0, RC,   32'h0000_0004);

        reset = 1'b1;
        drive(0, 0, 0, 32'h0, 2'd0, 32'h0, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        check("reset_pc",   bus.f_PC, 32'h0000_3000);
        check("reset_addr", bus.i_inst_addr, 32'h0000_3000);
        check("reset_bd",   {31'b0, bus.f_BD}, 32'h0);
        check("reset_exc",  {27'b0, bus.f_ExcCode}, 32'h0);
        check("reset_instr", bus.f_Instr, mem(32'h0000_3000));

        for (int i = 0; i < 19; i++) begin
            drive(vecs[i].req, vecs[i].stall, vecs[i].eret, vecs[i].epc,
                  vecs[i].sel, vecs[i].target, vecs[i].bj);
            sb_q.push_back(vecs[i].exp_next);
            #1;
            check($sformatf("v%0d_pc", i),   bus.f_PC, vecs[i].exp_pc);
            check($sformatf("v%0d_bd", i),   {31'b0, bus.f_BD}, {31'b0, vecs[i].exp_bd});
            check($sformatf("v%0d_exc", i),  {27'b0, bus.f_ExcCode}, {27'b0, vecs[i].exp_exc});
            check($sformatf("v%0d_instr", i), bus.f_Instr,
                  (vecs[i].exp_exc != 5'd0) ? 32'h0 : mem(vecs[i].exp_pc));
            @(posedge clk);
            #1;
            pop_check($sformatf("v%0d_next", i));
        end

        // Reset overriding a stall with a pending exception request.
        drive(1, 1, 1, 32'h0000_3300, 2'd3, 32'h0000_5000, 1);
        reset = 1'b1;
        sb_q.push_back(32'h0000_3000);
        @(posedge clk);
        #1 reset = 1'b0;
        pop_check("rst_mid_stall");

        // Reset overriding a taken jump, then a plain increment afterwards.
        drive(0, 0, 0, 32'h0, 2'd3, 32'h0000_5000, 1);
        sb_q.push_back(32'h0000_5000);
        @(posedge clk);
        #1;
        pop_check("jr_5000");
        drive(0, 0, 0, 32'h0, 2'd2, 32'h0000_6000, 1);
        reset = 1'b1;
        sb_q.push_back(32'h0000_3000);
        @(posedge clk);
        #1 reset = 1'b0;
        pop_check("rst_mid_redirect");
        drive(0, 0, 0, 32'h0, 2'd0, 32'h0, 0);
        #1;
        check("post_rst_bd", {31'b0, bus.f_BD}, 32'h0);
        sb_q.push_back(32'h0000_3004);
        @(posedge clk);
        #1;
        pop_check("post_rst_inc");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
